// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipeline_stall_controller_pkg;

   // FSM state encoding, also exported on the debug state port.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   // Width of the memory-wait cycle counter; MAX_MEM_WAIT must fit in it.
   localparam int WAIT_W = 8;

   // Increment a wait count, holding at the given ceiling.
   function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] cnt,
                                                  input logic [WAIT_W-1:0] ceil);
      return (cnt >= ceil) ? ceil : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module pipeline_stall_controller_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear, else increment unless already all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: turns hazard, branch and data-memory handshake
// into per-stage freeze/bubble/flush/mem_stall controls and tracks memory waits.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_RUN      | normal flow; branch/hazard handled, a blocked access enters wait
//   ST_MEM_WAIT | data memory access outstanding; pipeline held until release
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int MAX_MEM_WAIT = 63
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             hazard_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   input  logic             perf_clr_i,
   output logic             freeze_o,
   output logic             bubble_o,
   output logic             flush_o,
   output logic             mem_stall_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o,
   output logic             state_o
);

   localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(MAX_MEM_WAIT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic              mem_block;

   // An access that cannot complete this cycle blocks the pipe in either state;
   // once it clears, the same cycle falls through to the branch/hazard rules.
   assign mem_block = mem_req_i & ~mem_ready_i;

   // Mealy stage controls, forced quiet while reset is asserted.
   always_comb begin
      freeze_o    = 1'b0;
      bubble_o    = 1'b0;
      flush_o     = 1'b0;
      mem_stall_o = 1'b0;
      if (rst_ni) begin
         if (mem_block) begin
            mem_stall_o = 1'b1;
            freeze_o    = 1'b1;
         end else if (branch_taken_i) begin
            flush_o = 1'b1;
         end else if (hazard_i) begin
            freeze_o = 1'b1;
            bubble_o = 1'b1;
         end
      end
   end

   // Next state, wait length and sticky timeout.
   always_comb begin
      state_d       = ST_RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = mem_timeout_q;
      if (mem_block) begin
         state_d    = ST_MEM_WAIT;
         wait_cnt_d = (state_q == ST_RUN) ? WAIT_W'(1) : wait_inc(wait_cnt_q, MAX_WAIT);
         if (wait_cnt_d == MAX_WAIT) begin
            mem_timeout_d = 1'b1;
         end
      end
   end

   // FSM and wait-tracking registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout_o = mem_timeout_q;
   assign state_o       = state_q;

   pipeline_stall_controller_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (perf_clr_i),
      .inc_i  (freeze_o),
      .q_o    (stall_cycles_o)
   );

   pipeline_stall_controller_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (perf_clr_i),
      .inc_i  (flush_o),
      .q_o    (flush_count_o)
   );

endmodule
